aftab_memory_arbiter: RTL
=========================

// Module: aftab_memory_arbiter
// PURPOSE
// Shares the single-port aftab_memory_model between two requesters:
// port 0 (instruction fetch) and port 1 (data/debugger access).
// Arbitrates, latches the winning request, drives readmem/writemem/addressBus/dataBusIn,
// waits for memDataReady, returns read data and a one-cycle ready pulse to the winner.
// Includes a watchdog that completes a stalled access with an error flag.
// PARAMETERS
// dataWidth      8   width of memory data bus and requester data
// addressWidth   32  width of memory address bus and requester address
// timeoutCycles  64  max cycles in ACCESS before forced error completion (>=2)
// PORTS
// clk            in   1             single clock, all state on rising edge
// rst            in   1             asynchronous, active-low reset
// p0_read        in   1             port 0 read request (level, held until p0_ready)
// p0_write       in   1             port 0 write request (level, held until p0_ready)
// p0_addr        in   addressWidth  port 0 address
// p0_wdata       in   dataWidth     port 0 write data
// p0_rdata       out  dataWidth     port 0 read data, valid while p0_ready=1
// p0_ready       out  1             port 0 completion pulse (1 cycle)
// p0_error       out  1             port 0 timeout flag, qualified by p0_ready
// p1_*           same set as p0_*   port 1 (read, write, addr, wdata, rdata, ready, error)
// readmem        out  1             memory read strobe
// writemem       out  1             memory write strobe
// addressBus     out  addressWidth  memory address (registered)
// dataBusIn      out  dataWidth     memory write data (registered)
// dataBusOut     in   dataWidth     memory read data
// memDataReady   in   1             memory completion (level)
// BEHAVIOUR
// - Reset (rst=0, async): all outputs 0, state IDLE, watchdog 0, lastGrant=1 (port 0 wins first tie).
// - Reset mid-access: strobes drop immediately; no ready pulse issued; memory left to settle.
// - States: IDLE -> ACCESS -> RELEASE -> IDLE. All outputs registered.
// - IDLE: port k requesting if pk_read|pk_write. One requester: grant it. Both: grant the port
//   that is not lastGrant (round-robin). On grant edge: latch addr/wdata into addressBus/dataBusIn,
//   set writemem if pk_write else readmem, update lastGrant, clear watchdog, go ACCESS.
//   Strobes are high from the cycle after the request is first sampled.
// - pk_read and pk_write both high: treated as write; read ignored.
// - ACCESS: hold strobes, address, data constant; watchdog increments each cycle.
//   memDataReady=1 sampled: capture dataBusOut into pk_rdata (reads only; writes leave rdata),
//   pk_ready=1 for exactly the next cycle, pk_error=0, strobes to 0, go RELEASE.
//   Watchdog reaches timeoutCycles-1 with memDataReady=0: pk_ready=1, pk_error=1,
//   pk_rdata={dataWidth{1'b1}}, strobes to 0, go RELEASE. memDataReady wins if both on same edge.
// - RELEASE: strobes 0; requests ignored; stay until memDataReady=0 sampled, then IDLE.
//   Requester must drop its request in the ready cycle; a request still high when IDLE is
//   re-entered is a new access.
// - Ungranted port waits with no response; its request inputs are not sampled until IDLE.
// - pk_rdata holds its last value between accesses; pk_error clears with the next ready pulse.
// - Minimum turnaround: grant edge, >=1 ACCESS cycle, 1 RELEASE cycle.
// - Watchdog width $clog2(timeoutCycles); never wraps (leaves ACCESS at terminal count).
// TESTING
// 1 Port 0 read addr 0x10, memory returns 0xA5 after 5 cycles -> readmem high 5+ cycles,
//   p0_ready 1 cycle, p0_rdata=0xA5, p0_error=0, p1_ready stays 0.
// 2 Port 1 write addr 0x1004 data 0x3C -> writemem=1, addressBus=0x1004, dataBusIn=0x3C
//   until memDataReady; p1_ready pulse, p1_rdata unchanged.
// 3 Both ports read together, repeated 4 times -> grants alternate 0,1,0,1
//   (first grant port 0 after reset).
// 4 Memory never asserts memDataReady, timeoutCycles=64 -> strobe drops after 64 ACCESS cycles,
//   ready=1, error=1, rdata=0xFF; next access completes with error=0.
// 5 rst low while readmem=1 -> readmem/ready/rdata 0 asynchronously; after release,
//   a new port 1 request is served normally.
// 6 Read and write both high on port 0 -> writemem=1, readmem=0.

Source files
------------

// File: rtl/aftab_memory_arbiter.sv
// -----------------------------------------------------------------------------
// aftab_memory_arbiter
//
// Shares one single-port memory between two requesters: port 0 (instruction
// fetch) and port 1 (data / debugger). A request is a held level on
// pk_read / pk_write. The arbiter grants one port (round-robin on a tie),
// registers its address and write data onto the memory bus, holds the strobe
// until memDataReady, then returns a one-cycle pk_ready pulse, read data and
// an error flag. A watchdog forces completion with pk_error=1 if the memory
// never answers.
//
// Ports
//   clk, rst                 clock; asynchronous active-low reset
//   pk_read, pk_write        port k request levels (write wins if both high)
//   pk_addr, pk_wdata        port k address / write data
//   pk_rdata                 port k read data, valid while pk_ready=1
//   pk_ready                 port k one-cycle completion pulse
//   pk_error                 port k watchdog-timeout flag, qualified by pk_ready
//   readmem, writemem        memory strobes (registered)
//   addressBus, dataBusIn    memory address / write data (registered)
//   dataBusOut               memory read data
//   memDataReady             memory completion level
// -----------------------------------------------------------------------------
module aftab_memory_arbiter #(
    parameter int dataWidth     = 8,
    parameter int addressWidth  = 32,
    parameter int timeoutCycles = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    p0_read,
    input  logic                    p0_write,
    input  logic [addressWidth-1:0] p0_addr,
    input  logic [dataWidth-1:0]    p0_wdata,
    output logic [dataWidth-1:0]    p0_rdata,
    output logic                    p0_ready,
    output logic                    p0_error,
    input  logic                    p1_read,
    input  logic                    p1_write,
    input  logic [addressWidth-1:0] p1_addr,
    input  logic [dataWidth-1:0]    p1_wdata,
    output logic [dataWidth-1:0]    p1_rdata,
    output logic                    p1_ready,
    output logic                    p1_error,
    output logic                    readmem,
    output logic                    writemem,
    output logic [addressWidth-1:0] addressBus,
    output logic [dataWidth-1:0]    dataBusIn,
    input  logic [dataWidth-1:0]    dataBusOut,
    input  logic                    memDataReady
);

    localparam int WdogWidth = $clog2(timeoutCycles);
    // Terminal count: the watchdog leaves ACCESS here instead of wrapping.
    localparam logic [WdogWidth-1:0] WdogLast = WdogWidth'(timeoutCycles - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [WdogWidth-1:0]    wdog_q, wdog_d;
    logic                    last_grant_q, last_grant_d;
    logic                    owner_q, owner_d;        // port being served
    logic                    readmem_q, readmem_d;
    logic                    writemem_q, writemem_d;
    logic [addressWidth-1:0] addr_q, addr_d;
    logic [dataWidth-1:0]    wdata_q, wdata_d;
    logic [dataWidth-1:0]    rdata_q [2];
    logic [dataWidth-1:0]    rdata_d [2];
    logic [1:0]              ready_q, ready_d;
    logic [1:0]              error_q, error_d;

    logic req0, req1, win, win_write;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d      = state_q;
        wdog_d       = wdog_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        readmem_d    = readmem_q;
        writemem_d   = writemem_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        ready_d      = 2'b00;       // ready is a pulse: low unless set below
        error_d      = error_q;
        req0         = p0_read | p0_write;
        req1         = p1_read | p1_write;
        win          = 1'b0;
        win_write    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    // On a tie the port that did not win last time goes next.
                    win          = (req0 && req1) ? ~last_grant_q : req1;
                    win_write    = win ? p1_write : p0_write;
                    owner_d      = win;
                    last_grant_d = win;
                    wdog_d       = '0;
                    writemem_d   = win_write;
                    readmem_d    = ~win_write;
                    addr_d       = win ? p1_addr : p0_addr;
                    wdata_d      = win ? p1_wdata : p0_wdata;
                    state_d      = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // memDataReady has priority over a watchdog expiry on the same edge.
                if (memDataReady) begin
                    ready_d[owner_q] = 1'b1;
                    error_d[owner_q] = 1'b0;
                    if (readmem_q) begin
                        rdata_d[owner_q] = dataBusOut;
                    end
                    readmem_d  = 1'b0;
                    writemem_d = 1'b0;
                    state_d    = ST_RELEASE;
                end else if (wdog_q == WdogLast) begin
                    ready_d[owner_q] = 1'b1;
                    error_d[owner_q] = 1'b1;
                    rdata_d[owner_q] = '1;
                    readmem_d  = 1'b0;
                    writemem_d = 1'b0;
                    state_d    = ST_RELEASE;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            ST_RELEASE: begin
                // Let the memory drop its ready level before accepting new work.
                if (!memDataReady) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            wdog_q       <= '0;
            last_grant_q <= 1'b1;   // so port 0 wins the first tie
            owner_q      <= 1'b0;
            readmem_q    <= 1'b0;
            writemem_q   <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q[0]   <= '0;
            rdata_q[1]   <= '0;
            ready_q      <= 2'b00;
            error_q      <= 2'b00;
        end else begin
            // NOTE: non-blocking assignments make every flop update from the
            // pre-edge values, independent of statement order.
            state_q      <= state_d;
            wdog_q       <= wdog_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            readmem_q    <= readmem_d;
            writemem_q   <= writemem_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            ready_q      <= ready_d;
            error_q      <= error_d;
        end
    end

    assign readmem    = readmem_q;
    assign writemem   = writemem_q;
    assign addressBus = addr_q;
    assign dataBusIn  = wdata_q;
    assign p0_rdata   = rdata_q[0];
    assign p1_rdata   = rdata_q[1];
    assign p0_ready   = ready_q[0];
    assign p1_ready   = ready_q[1];
    assign p0_error   = error_q[0];
    assign p1_error   = error_q[1];

endmodule
